alu_wide_seq: RTL and testbench
===============================

# alu_wide_seq

Multi-cycle sequencer that drives the 8-bit combinational ALU to perform 16-bit add, shift-left, shift-right and compare operations. It is the initiator side of the ALU command interface: it issues `alu_cmd`/operands/shift-carry-in, samples `rslt`/`sc_o`/`equal` back, and chains the carry between byte halves. It sits between the core's control path and the ALU, and handles wide arithmetic for programs that need 16-bit values.

## Interface
Parameters:
- none (byte width fixed at 8, word width fixed at 16)

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only in IDLE
- `op`  in  2  wide op: 0=ADD16, 1=SHL16, 2=SHR16, 3=CMP16
- `a`  in  16  operand A, captured on accept
- `b`  in  16  operand B, captured on accept (ignored for shifts)
- `cin`  in  1  carry-in / shift-in bit, captured on accept
- `alu_cmd`  out  4  command to ALU
- `alu_inA`  out  8  ALU operand A
- `alu_inB`  out  8  ALU operand B
- `alu_sc_i`  out  1  ALU shift/carry in
- `alu_rslt`  in  8  ALU result
- `alu_sc_o`  in  1  ALU shift/carry out
- `alu_equal`  in  1  ALU equality flag
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `result`  out  16  wide result
- `carry_out`  out  1  final carry/shifted-out bit
- `eq`  out  1  16-bit equality (CMP16 only)

## Operation
- States: IDLE → FIRST → SECOND → DONE → IDLE.
- IDLE: drive `alu_cmd`=4'b1111 (NOP), `alu_inA`/`alu_inB`/`alu_sc_i`=0. When `start`=1, capture `op`, `a`, `b`, `cin` and go to FIRST.
- Byte order: ADD16, SHL16 and CMP16 process the low byte in FIRST and the high byte in SECOND. SHR16 processes the high byte first and the low byte second.
- ALU commands:
  - ADD16 → 4'b0000
  - SHL16 → 4'b0001
  - SHR16 → 4'b0010
  - CMP16 → 4'b1101
- FIRST: `alu_sc_i`=captured `cin`. At the clock edge, latch `alu_rslt` into the appropriate result byte and `alu_sc_o` into the internal carry flop.
- SECOND: `alu_sc_i`=internal carry flop. At the clock edge, latch the other result byte and capture `alu_sc_o` into `carry_out`.
- CMP16 result handling:
  - In FIRST, latch `alu_equal` into an internal flop.
  - In SECOND, `eq` ← flop & `alu_equal`.
  - `result` and `carry_out` are not modified by CMP16.
- Field scope: `eq` is updated only by CMP16. `result`/`carry_out` are updated only by ADD16/SHL16/SHR16.
- DONE: `done`=1 for exactly this cycle, `busy`=1, ALU driven with NOP. Next state is IDLE unconditionally.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` held high continuously produces back-to-back operations with one IDLE cycle between them.
- Arithmetic is modulo 2^16. Carry out of bit 15 (ADD) or the shifted-out bit (SHL: old a[15]; SHR: old a[0]) goes to `carry_out`.

## Timing
- Accept at edge k (IDLE, `start`=1). FIRST is active during cycle k+1, SECOND during k+2, DONE during k+3. `done` is high in cycle k+3.
- `result`/`carry_out`/`eq` are valid from cycle k+3 and held stable until the next accepted operation completes its relevant phase.
- ALU outputs are combinational. Sampling happens at the edge that ends each of FIRST and SECOND, with no extra wait cycle.
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=16'h0000, `carry_out`=0, `eq`=0, internal carry/equal flops=0, ALU drive=NOP/0.
- Reset asserted mid-operation: next cycle is IDLE with all reset values. No `done` pulse is emitted for the aborted op.
- Reset and `start` in the same cycle: reset wins and the op is not accepted.

## Structure
- Shared package `alu_pkg`:
  - ALU command constants: ALU_ADD=4'b0000, ALU_LSH=4'b0001, ALU_RSH=4'b0010, ALU_MOV=4'b0011, ALU_OR=4'b0100, ALU_XOR=4'b0101, ALU_AND=4'b0110, ALU_ADDI=4'b0111, ALU_BNE=4'b1000, ALU_BEQ=4'b1001, ALU_MOVI=4'b1010, ALU_CMP=4'b1101, ALU_NOP=4'b1111.
  - `wide_op_t` enum (ADD16, SHL16, SHR16, CMP16).
- State enum `seq_state_t` stays local to the module.
- No sub-module inside. The bench instantiates the existing ALU next to this block, wired port-to-port.

## Test plan
- ADD16 a=16'h00FF, b=16'h0001, cin=0 → `result`=16'h0100, `carry_out`=0. `done` is high exactly 3 cycles after the accept edge, and `busy` is high for 3 cycles.
- ADD16 a=16'hFFFF, b=16'h0001, cin=0 → `result`=16'h0000, `carry_out`=1.
- SHL16 a=16'h8001, cin=1 → `result`=16'h0003, `carry_out`=1.
- SHR16 a=16'h0181, cin=1 → `result`=16'h80C0, `carry_out`=1. Also check the ALU sees the high byte first (`alu_inA`=8'h01 in FIRST).
- CMP16 a=b=16'h1234 → `eq`=1. Then CMP16 a=16'h1234, b=16'h1334 → `eq`=0. `result` keeps its prior value throughout.
- Reset in SECOND of an ADD16 → no `done`, all outputs at reset values next cycle. Separately, pulse `start` while `busy` → ignored, only one `done` observed.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the 8-bit ALU command encodings, the wide operation
// codes handled by the 16-bit sequencer, and the mapping between the two.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_LSH  = 4'b0001;
  localparam logic [3:0] ALU_RSH  = 4'b0010;
  localparam logic [3:0] ALU_MOV  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_ADDI = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;
  localparam logic [3:0] ALU_MOVI = 4'b1010;
  localparam logic [3:0] ALU_CMP  = 4'b1101;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    ADD16 = 2'd0,
    SHL16 = 2'd1,
    SHR16 = 2'd2,
    CMP16 = 2'd3
  } wide_op_t;

  // Byte-level ALU command used for both halves of a wide operation.
  function automatic logic [3:0] wide_cmd(input wide_op_t o);
    logic [3:0] c;
    case (o)
      ADD16:   c = ALU_ADD;
      SHL16:   c = ALU_LSH;
      SHR16:   c = ALU_RSH;
      CMP16:   c = ALU_CMP;
      default: c = ALU_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// 16-bit operation sequencer on top of the 8-bit combinational ALU.
// Runs each wide op as two byte passes (FIRST, SECOND) followed by a DONE
// cycle, chaining the ALU carry/shift bit between the passes.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, op, a, b, cin       request and operands (sampled when IDLE)
//   alu_cmd/inA/inB/sc_i       drive to the ALU
//   alu_rslt/sc_o/equal        ALU response, sampled at the end of each pass
//   busy, done                 status (busy outside IDLE, done pulse in DONE)
//   result, carry_out, eq      registered wide results
module alu_wide_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [3:0]  alu_cmd,
  output logic [7:0]  alu_inA,
  output logic [7:0]  alu_inB,
  output logic        alu_sc_i,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_sc_o,
  input  logic        alu_equal,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        eq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_DONE   = 2'd3
  } seq_state_t;

  seq_state_t  state_r, state_s;
  wide_op_t    op_r;
  logic [15:0] a_r, b_r;
  logic        cin_r;
  logic        carry_r;
  logic        eq_first_r;
  logic        hi_first_s;

  // A right shift must see the high byte first so its shifted-out bit can
  // enter the low byte; every other op ripples from the low byte up.
  assign hi_first_s = (op_r == SHR16);

  assign busy = (state_r != S_IDLE);
  assign done = (state_r == S_DONE);

  // Next-state selection and ALU drive for the current pass.
  always_comb begin
    state_s  = state_r;
    alu_cmd  = ALU_NOP;
    alu_inA  = 8'h00;
    alu_inB  = 8'h00;
    alu_sc_i = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_FIRST;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FIRST: begin
        alu_cmd  = wide_cmd(op_r);
        alu_inA  = hi_first_s ? a_r[15:8] : a_r[7:0];
        alu_inB  = hi_first_s ? b_r[15:8] : b_r[7:0];
        alu_sc_i = cin_r;
        state_s  = S_SECOND;
      end
      S_SECOND: begin
        alu_cmd  = wide_cmd(op_r);
        alu_inA  = hi_first_s ? a_r[7:0] : a_r[15:8];
        alu_inB  = hi_first_s ? b_r[7:0] : b_r[15:8];
        alu_sc_i = carry_r;
        state_s  = S_DONE;
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and per-pass result latching.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r       <= ADD16;
      a_r        <= 16'h0000;
      b_r        <= 16'h0000;
      cin_r      <= 1'b0;
      carry_r    <= 1'b0;
      eq_first_r <= 1'b0;
      result     <= 16'h0000;
      carry_out  <= 1'b0;
      eq         <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_r  <= wide_op_t'(op);
            a_r   <= a;
            b_r   <= b;
            cin_r <= cin;
          end
        end
        S_FIRST: begin
          carry_r <= alu_sc_o;
          // A compare leaves result/carry_out untouched.
          if (op_r == CMP16) begin
            eq_first_r <= alu_equal;
          end else if (hi_first_s) begin
            result[15:8] <= alu_rslt;
          end else begin
            result[7:0] <= alu_rslt;
          end
        end
        S_SECOND: begin
          if (op_r == CMP16) begin
            eq <= eq_first_r & alu_equal;
          end else begin
            carry_out <= alu_sc_o;
            if (hi_first_s) begin
              result[7:0] <= alu_rslt;
            end else begin
              result[15:8] <= alu_rslt;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq. A behavioural 8-bit ALU sits next to
// the sequencer; a word-level reference model predicts status and results
// each cycle, and directed cases pin the model with literal expectations.
module tb_alu_wide_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        cin = 1'b0;
  logic [3:0]  alu_cmd;
  logic [7:0]  alu_inA, alu_inB;
  logic        alu_sc_i;
  logic [7:0]  alu_rslt;
  logic        alu_sc_o;
  logic        alu_equal;
  logic        busy, done;
  logic [15:0] result;
  logic        carry_out, eq;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  alu_wide_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sc_i(alu_sc_i),
    .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_equal(alu_equal),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .eq(eq)
  );

  // Behavioural 8-bit ALU (combinational).
  always_comb begin
    alu_rslt  = 8'h00;
    alu_sc_o  = 1'b0;
    alu_equal = (alu_inA == alu_inB);
    case (alu_cmd)
      4'b0000: {alu_sc_o, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'h00, alu_sc_i};
      4'b0001: begin alu_rslt = {alu_inA[6:0], alu_sc_i}; alu_sc_o = alu_inA[7]; end
      4'b0010: begin alu_rslt = {alu_sc_i, alu_inA[7:1]}; alu_sc_o = alu_inA[0]; end
      default: begin alu_rslt = 8'h00; alu_sc_o = 1'b0; end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Word-level reference model: cycles remaining in the op and the values the
  // visible outputs will hold once the op finishes its second pass.
  int          m_cnt = 0;
  bit          m_is_cmp = 1'b0;
  logic [15:0] m_result = 16'h0000, p_res = 16'h0000;
  logic        m_co = 1'b0, m_eq = 1'b0, p_co = 1'b0, p_eq = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0; m_result <= 16'h0000; m_co <= 1'b0; m_eq <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        logic [16:0] sum;
        m_cnt    <= 3;
        m_is_cmp <= (op == 2'd3);
        sum = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
        case (op)
          2'd0: begin p_res <= sum[15:0]; p_co <= sum[16]; end
          2'd1: begin p_res <= {a[14:0], cin}; p_co <= a[15]; end
          2'd2: begin p_res <= {cin, a[15:1]}; p_co <= a[0]; end
          default: p_eq <= (a == b);
        endcase
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        if (m_is_cmp) m_eq <= p_eq;
        else begin m_result <= p_res; m_co <= p_co; end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
      chk("done", {31'd0, done}, {31'd0, m_cnt == 1});
      chk("eq", {31'd0, eq}, {31'd0, m_eq});
      if (m_cnt == 0 || m_cnt == 1) chk("alu_nop", {28'd0, alu_cmd}, 32'hF);
      // Mid-op the result is half-updated; it is defined again from DONE.
      if (!(m_cnt == 2 && !m_is_cmp)) begin
        chk("result", {16'd0, result}, {16'd0, m_result});
        chk("carry_out", {31'd0, carry_out}, {31'd0, m_co});
      end
    end
  end

  // One directed op: checks first-pass ALU drive, latency and results.
  task automatic do_op(input logic [1:0] o, input logic [15:0] aa, input logic [15:0] bb,
                       input logic c, input logic [15:0] x_res, input logic x_co,
                       input logic x_eq, input logic [7:0] x_first_a);
    logic [3:0] cmd_tab [4];
    int lat;
    cmd_tab[0] = 4'b0000; cmd_tab[1] = 4'b0001; cmd_tab[2] = 4'b0010; cmd_tab[3] = 4'b1101;
    @(posedge clk); #1;
    op = o; a = aa; b = bb; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_cmd", {28'd0, alu_cmd}, {28'd0, cmd_tab[o]});
    chk("first_inA", {24'd0, alu_inA}, {24'd0, x_first_a});
    chk("first_sc_i", {31'd0, alu_sc_i}, {31'd0, c});
    lat = 0;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", lat, 2);
    chk("op_result", {16'd0, result}, {16'd0, x_res});
    chk("op_carry", {31'd0, carry_out}, {31'd0, x_co});
    chk("op_eq", {31'd0, eq}, {31'd0, x_eq});
    @(posedge clk); #1;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'h0000);
    chk("rst_cmd", {28'd0, alu_cmd}, 32'hF);
    chk("rst_inA", {24'd0, alu_inA}, 32'h00);

    do_op(2'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 8'hFF);
    do_op(2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hFF);
    do_op(2'd1, 16'h8001, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0, 8'h01);
    do_op(2'd2, 16'h0181, 16'h0000, 1'b1, 16'h80C0, 1'b1, 1'b0, 8'h01);
    do_op(2'd3, 16'h1234, 16'h1234, 1'b0, 16'h80C0, 1'b1, 1'b1, 8'h34);
    do_op(2'd3, 16'h1234, 16'h1334, 1'b0, 16'h80C0, 1'b1, 1'b0, 8'h34);

    // Reset during SECOND of an ADD16.
    @(posedge clk); #1;
    op = 2'd0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'h0000);
    chk("abort_carry", {31'd0, carry_out}, 32'd0);
    chk("abort_cmd", {28'd0, alu_cmd}, 32'hF);
    dones = 0;
    repeat (5) begin @(posedge clk); #1; if (done) dones++; end
    chk("abort_no_done", dones, 0);

    // start pulsed while busy is ignored.
    op = 2'd0; a = 16'h0102; b = 16'h0304; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dones = (done) ? 1 : 0;
    repeat (8) begin @(posedge clk); #1; if (done) dones++; end
    chk("busy_start_dones", dones, 1);
    chk("busy_start_result", {16'd0, result}, 32'h0407);

    // Randomized traffic, including held start and occasional reset.
    repeat (2500) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) != 0);
      op    = 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b     = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      cin   = 1'($urandom);
      reset = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
